tick_serializer: RTL and testbench

Serial transmitter that consumes the one-cycle `tick` strobe produced by the upstream pulse divider and uses it as its bit-rate enable. It accepts parallel words over a valid/ready handshake and shifts each out on `tx` as an asynchronous-style frame: start bit, data bits LSB first, optional even parity, one stop bit. All bit boundaries are aligned to `tick`, so the bit rate is the tick rate divided by `TICKS_PER_BIT`.

---
 rtl/tick_serializer.sv | 120 ++++++++++++
 tb/tb_tick_serializer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_serializer.sv
// rtl/tick_serializer.sv - tick-paced serial transmitter: start, LSB-first data, optional even parity, stop
module tick_serializer #(
    parameter int DATA_W        = 8,
    parameter int TICKS_PER_BIT = 2,
    parameter int PARITY_EN     = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx,
    output logic              busy
);
    localparam int TCW = $clog2(TICKS_PER_BIT + 1);
    localparam int BCW = $clog2(DATA_W + 1);
    localparam logic [TCW-1:0] TICK_LAST = TCW'(TICKS_PER_BIT - 1);
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_next;
    logic              parity;
    logic [TCW-1:0]    tick_cnt;
    logic [BCW-1:0]    bit_cnt;
    logic              bit_done;
    logic              in_bit_state;

    assign shreg_next   = shreg >> 1;
    assign bit_done     = tick && (tick_cnt == TICK_LAST);
    assign in_bit_state = (state == START) || (state == DATA) ||
                          (state == PARITY) || (state == STOP);

    assign in_ready = (state == IDLE) && !reset;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            shreg    <= '0;
            parity   <= 1'b0;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= 1'b1;
        end else begin
            // Shared per-bit tick counter for every state that holds a bit on the line
            if (in_bit_state && tick) begin
                tick_cnt <= bit_done ? '0 : tick_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (in_valid) begin
                        shreg  <= in_data;
                        parity <= ^in_data;
                        state  <= ARMED;
                    end
                end
                ARMED: begin
                    if (tick) begin
                        tx       <= 1'b0;
                        tick_cnt <= '0;
                        state    <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        tx      <= shreg[0];
                        bit_cnt <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        if (bit_cnt == BIT_LAST) begin
                            if (PARITY_EN != 0) begin
                                tx    <= parity;
                                state <= PARITY;
                            end else begin
                                tx    <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            shreg   <= shreg_next;
                            tx      <= shreg_next[0];
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (bit_done) begin
                        tx    <= 1'b1;
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        tx    <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tick_serializer.sv
// tb/tb_tick_serializer.sv - scoreboard bench for tick_serializer across three parameter sets
module tb_tick_serializer;
    localparam int TMO = 3000;

    logic       clk;
    logic       reset;
    logic       tick;
    logic       in_valid;
    logic [7:0] in_data;
    logic [1:0] sel;
    int         period;

    logic tick_a, tick_b, tick_c;
    logic valid_a, valid_b, valid_c;
    logic ready_a, ready_b, ready_c;
    logic tx_a, tx_b, tx_c;
    logic busy_a, busy_b, busy_c;
    logic ready_m, tx_m, busy_m;

    int vectors;
    int miscompares;

    logic [10:0] exp_q[$];
    int          nb_q[$];

    typedef struct {
        logic [1:0]  sel;
        int          period;
        logic [7:0]  data;
        logic [10:0] frame;
        int          nbits;
    } vec_t;
    vec_t vecs[6];

    assign tick_a  = tick & (sel == 2'd0);
    assign tick_b  = tick & (sel == 2'd1);
    assign tick_c  = tick & (sel == 2'd2);
    assign valid_a = in_valid & (sel == 2'd0);
    assign valid_b = in_valid & (sel == 2'd1);
    assign valid_c = in_valid & (sel == 2'd2);

    always_comb begin
        ready_m = ready_a;
        tx_m    = tx_a;
        busy_m  = busy_a;
        if (sel == 2'd1) begin
            ready_m = ready_b;
            tx_m    = tx_b;
            busy_m  = busy_b;
        end else if (sel == 2'd2) begin
            ready_m = ready_c;
            tx_m    = tx_c;
            busy_m  = busy_c;
        end
    end

    tick_serializer #(.DATA_W(8), .TICKS_PER_BIT(2), .PARITY_EN(0)) dut_a (
        .clk(clk), .reset(reset), .tick(tick_a), .in_data(in_data), .in_valid(valid_a),
        .in_ready(ready_a), .tx(tx_a), .busy(busy_a)
    );
    tick_serializer #(.DATA_W(8), .TICKS_PER_BIT(2), .PARITY_EN(1)) dut_b (
        .clk(clk), .reset(reset), .tick(tick_b), .in_data(in_data), .in_valid(valid_b),
        .in_ready(ready_b), .tx(tx_b), .busy(busy_b)
    );
    tick_serializer #(.DATA_W(8), .TICKS_PER_BIT(1), .PARITY_EN(0)) dut_c (
        .clk(clk), .reset(reset), .tick(tick_c), .in_data(in_data), .in_valid(valid_c),
        .in_ready(ready_c), .tx(tx_c), .busy(busy_c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Free-running tick strobe, one pulse every `period` cycles
    initial begin
        int cnt;
        cnt  = 0;
        tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (cnt >= period - 1) begin
                tick = 1'b1;
                cnt  = 0;
            end else begin
                tick = 1'b0;
                cnt++;
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %b required %b", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: timed out or no expected entry, got none required event", name);
    endtask

    task automatic send(input logic [7:0] d, input logic [10:0] f, input int nb);
        int n;
        in_data  = d;
        in_valid = 1'b1;
        n = 0;
        while (ready_m !== 1'b1 && n < TMO) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= TMO) fail_now("send_ready");
        exp_q.push_back(f);
        nb_q.push_back(nb);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("accept_ready_busy", {2'b00, ready_m, busy_m}, 4'b0001);
    endtask

    task automatic check_frame(input int cyc_per_bit, output int waited);
        int          n;
        logic [10:0] f;
        int          nb;
        logic        bad;
        logic        bad_tx;
        logic        bad_busy;
        n = 0;
        while (tx_m !== 1'b0 && n < TMO) begin
            @(posedge clk);
            #1;
            n++;
        end
        waited = n;
        if (n >= TMO) begin
            fail_now("start_bit");
            return;
        end
        if (exp_q.size() == 0) begin
            fail_now("scoreboard_empty");
            return;
        end
        f  = exp_q.pop_front();
        nb = nb_q.pop_front();
        for (int b = 0; b < nb; b++) begin
            bad      = 1'b0;
            bad_tx   = 1'b0;
            bad_busy = 1'b0;
            for (int k = 0; k < cyc_per_bit; k++) begin
                if (b != 0 || k != 0) begin
                    @(posedge clk);
                    #1;
                end
                if (!bad && (tx_m !== f[b] || busy_m !== 1'b1)) begin
                    bad      = 1'b1;
                    bad_tx   = tx_m;
                    bad_busy = busy_m;
                end
            end
            vectors++;
            if (bad) begin
                miscompares++;
                $display("FAIL frame_bit%0d: got tx=%b busy=%b required tx=%b busy=1",
                         b, bad_tx, bad_busy, f[b]);
            end
        end
        @(posedge clk);
        #1;
        check("after_stop ready,busy,tx", {1'b0, ready_m, busy_m, tx_m}, 4'b0101);
    endtask

    initial begin
        int  w;
        int  n;
        logic bad;

        vectors     = 0;
        miscompares = 0;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        sel      = 2'd0;
        period   = 5;

        vecs[0] = '{2'd0, 5, 8'hA5, 11'h34A, 10};
        vecs[1] = '{2'd1, 5, 8'h07, 11'h60E, 11};
        vecs[2] = '{2'd1, 5, 8'h03, 11'h406, 11};
        vecs[3] = '{2'd2, 1, 8'h81, 11'h302, 10};
        vecs[4] = '{2'd1, 3, 8'h3C, 11'h478, 11};
        vecs[5] = '{2'd0, 1, 8'h0F, 11'h21E, 10};

        @(posedge clk);
        #1;
        check("reset ready,busy,tx", {1'b0, ready_m, busy_m, tx_m}, 4'b0001);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_reset", {3'b000, ready_m}, 4'b0001);

        // Idle line with ticks running and no valid
        bad = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (tx_m !== 1'b1 || busy_m !== 1'b0) bad = 1'b1;
        end
        check("idle_line bad", {3'b000, bad}, 4'b0000);

        for (int i = 0; i < 6; i++) begin
            sel    = vecs[i].sel;
            period = vecs[i].period;
            repeat (3) @(posedge clk);
            #1;
            fork
                send(vecs[i].data, vecs[i].frame, vecs[i].nbits);
                check_frame((vecs[i].sel == 2'd2) ? vecs[i].period : 2 * vecs[i].period, w);
            join
        end

        // Back-to-back with valid held
        sel    = 2'd0;
        period = 5;
        repeat (3) @(posedge clk);
        #1;
        fork
            begin
                send(8'h55, 11'h2AA, 10);
                send(8'hFF, 11'h3FE, 10);
            end
            begin
                check_frame(10, w);
                check_frame(10, w);
                check("b2b_start_gap", 4'(w), 4'(period));
            end
        join

        // Data changing while busy must not affect the latched word
        repeat (3) @(posedge clk);
        #1;
        fork
            begin
                send(8'h96, 11'h32C, 10);
                repeat (100) begin
                    @(posedge clk);
                    #1;
                    in_data = 8'($urandom);
                end
            end
            check_frame(10, w);
        join

        // Reset during data bit 3 of 0x00
        repeat (3) @(posedge clk);
        #1;
        send(8'h00, 11'h200, 10);
        n = 0;
        while (tx_m !== 1'b0 && n < TMO) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= TMO) fail_now("abort_start");
        repeat (44) @(posedge clk);
        #1;
        check("pre_abort tx,busy", {2'b00, tx_m, busy_m}, 4'b0001);
        exp_q.delete();
        nb_q.delete();
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort ready,busy,tx", {1'b0, ready_m, busy_m, tx_m}, 4'b0001);
        reset = 1'b0;
        #1;
        check("ready_after_abort", {3'b000, ready_m}, 4'b0001);
        bad = 1'b0;
        repeat (200) begin
            @(posedge clk);
            #1;
            if (tx_m !== 1'b1 || busy_m !== 1'b0) bad = 1'b1;
        end
        check("no_resume bad", {3'b000, bad}, 4'b0000);
        fork
            send(8'h3C, 11'h278, 10);
            check_frame(10, w);
        join

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
